// File: rtl/move_gen_scheduler.sv
// move_gen_scheduler: board-level sequencer for the eight column move generators.
// Latches a board, resets the columns, waits for them (with a watchdog), then
// drains the column FIFOs in column order and streams valid moves out.
//
// state | meaning
// IDLE  | waiting for start
// RST   | col_reset held high for RST_CYCLES cycles
// GEN   | waiting for all col_done, watchdog running
// SEL   | pick lowest non-empty column FIFO, or finish
// RD    | one-cycle read enable to the selected column
// LAT   | FIFO q valid, capture word and its valid-slot mask
// SER   | stream pending slots over valid/ready
// FIN   | one-cycle gen_done pulse
module move_gen_scheduler #(
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned GEN_TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [255:0]  board_state_i,
    output logic [255:0]  col_state_o,
    output logic          col_reset_o,
    input  logic [7:0]    col_done_i,
    input  logic [7:0]    col_empty_i,
    output logic [7:0]    col_rden_o,
    input  logic [1279:0] col_data_i,
    output logic [18:0]   move_out_o,
    output logic          move_valid_o,
    input  logic          move_ready_i,
    output logic          busy_o,
    output logic          gen_done_o,
    output logic [7:0]    move_count_o,
    output logic          timeout_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_GEN, S_SEL, S_RD, S_LAT, S_SER, S_FIN
    } state_t;

    localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES);
    localparam logic [9:0] WD_LAST  = 10'(GEN_TIMEOUT - 1);

    state_t            state_q;
    logic [3:0]        rst_cnt_q;
    logic [9:0]        wd_cnt_q;
    logic [2:0]        col_q;
    logic [7:0][18:0]  slots_q;
    logic [7:0]        pend_q;
    logic [255:0]      col_state_q;
    logic [7:0]        col_rden_q;
    logic [18:0]       move_out_q;
    logic              move_valid_q;
    logic              gen_done_q;
    logic [7:0]        count_q;
    logic              timeout_q;

    logic [7:0][18:0]  lat_slots;
    logic [7:0]        lat_mask;
    logic [7:0]        pend_d;
    logic [2:0]        sel_idx;
    logic [63:0]       rsv_unused;

    function automatic logic [2:0] lowest_idx(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Slice the selected column's FIFO word into slots; reserved bits are dropped.
    always_comb begin
        lat_slots  = '0;
        lat_mask   = '0;
        rsv_unused = '0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) begin
                rsv_unused[8*c+k] = col_data_i[160*c + 20*k + 19];
                if (col_q == 3'(c)) begin
                    lat_slots[k] = col_data_i[160*c + 20*k +: 19];
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            lat_mask[k] = ~lat_slots[k][18];
        end
        pend_d  = pend_q & ~(8'd1 << lowest_idx(pend_q));
        sel_idx = lowest_idx(~col_empty_i);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            wd_cnt_q     <= '0;
            col_q        <= '0;
            slots_q      <= '0;
            pend_q       <= '0;
            col_state_q  <= '0;
            col_rden_q   <= '0;
            move_out_q   <= '0;
            move_valid_q <= 1'b0;
            gen_done_q   <= 1'b0;
            count_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            gen_done_q <= 1'b0;
            col_rden_q <= 8'd0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        col_state_q <= board_state_i;
                        count_q     <= '0;
                        timeout_q   <= 1'b0;
                        rst_cnt_q   <= RST_LOAD;
                        state_q     <= S_RST;
                    end
                end
                S_RST: begin
                    if (rst_cnt_q == 4'd1) begin
                        wd_cnt_q <= '0;
                        state_q  <= S_GEN;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 4'd1;
                    end
                end
                S_GEN: begin
                    // completion wins over a watchdog expiring in the same cycle
                    if (&col_done_i) begin
                        state_q <= S_SEL;
                    end else if (wd_cnt_q == WD_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_SEL;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 10'd1;
                    end
                end
                S_SEL: begin
                    if (&col_empty_i) begin
                        gen_done_q <= 1'b1;
                        state_q    <= S_FIN;
                    end else begin
                        col_q      <= sel_idx;
                        col_rden_q <= 8'd1 << sel_idx;
                        state_q    <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= S_LAT;
                end
                S_LAT: begin
                    slots_q <= lat_slots;
                    pend_q  <= lat_mask;
                    if (lat_mask == 8'd0) begin
                        state_q <= S_SEL;
                    end else begin
                        move_out_q   <= lat_slots[lowest_idx(lat_mask)];
                        move_valid_q <= 1'b1;
                        state_q      <= S_SER;
                    end
                end
                S_SER: begin
                    if (move_ready_i) begin
                        pend_q <= pend_d;
                        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
                        if (pend_d == 8'd0) begin
                            move_valid_q <= 1'b0;
                            state_q      <= S_SEL;
                        end else begin
                            move_out_q <= slots_q[lowest_idx(pend_d)];
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign col_state_o  = col_state_q;
    assign col_reset_o  = reset | (state_q == S_RST);
    assign col_rden_o   = col_rden_q;
    assign move_out_o   = move_out_q;
    assign move_valid_o = move_valid_q;
    assign busy_o       = (state_q != S_IDLE);
    assign gen_done_o   = gen_done_q;
    assign move_count_o = count_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_move_gen_scheduler.sv
// Testbench for move_gen_scheduler: FIFO model per column, expected-move
// queue derived from the loaded words, and directed generation scenarios.
module tb_move_gen_scheduler;
    logic          clk;
    logic          reset;
    logic          start;
    logic [255:0]  board_state;
    logic [255:0]  col_state;
    logic          col_reset;
    logic [7:0]    col_done;
    logic [7:0]    col_empty;
    logic [7:0]    col_rden;
    logic [1279:0] col_data;
    logic [18:0]   move_out;
    logic          move_valid;
    logic          move_ready;
    logic          busy;
    logic          gen_done;
    logic [7:0]    move_count;
    logic          timeout;

    move_gen_scheduler #(.RST_CYCLES(2), .GEN_TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset), .start_i(start), .board_state_i(board_state),
        .col_state_o(col_state), .col_reset_o(col_reset), .col_done_i(col_done),
        .col_empty_i(col_empty), .col_rden_o(col_rden), .col_data_i(col_data),
        .move_out_o(move_out), .move_valid_o(move_valid), .move_ready_i(move_ready),
        .busy_o(busy), .gen_done_o(gen_done), .move_count_o(move_count), .timeout_o(timeout)
    );

    typedef struct {
        int           col;
        logic [159:0] w;
    } ent_t;

    ent_t        store[$];
    logic [18:0] exp_moves[$];
    int          exp_pops[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          ready_mode = 2;
    int          hs_count = 0;
    int          valid_cycles = 0;
    logic        prev_hold = 1'b0;
    logic [18:0] prev_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Word with the given valid mask; payloads derived from base, reserved bits random.
    function automatic logic [159:0] mk_word(input logic [7:0] valid, input logic [17:0] base);
        logic [159:0] w;
        logic [17:0]  p;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            p = base + 18'(k * 37 + 5);
            w[20*k +: 20] = {1'($urandom_range(0, 1)), ~valid[k], p};
        end
        return w;
    endfunction

    task automatic add_word(input int c, input logic [159:0] w);
        ent_t e;
        e.col = c;
        e.w   = w;
        store.push_back(e);
    endtask

    // Expected output: columns in index order, words in FIFO order, valid slots in slot order.
    task automatic build_expected();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < store.size(); i++) begin
                if (store[i].col == c) begin
                    exp_pops.push_back(c);
                    for (int k = 0; k < 8; k++) begin
                        if (store[i].w[20*k+18] == 1'b0) exp_moves.push_back(store[i].w[20*k +: 19]);
                    end
                end
            end
        end
    endtask

    task automatic clear_model();
        store.delete();
        exp_moves.delete();
        exp_pops.delete();
    endtask

    task automatic pulse_start(input logic [255:0] b);
        board_state = b;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic count_rst(output int n);
        n = 0;
        while (col_reset && n < 20) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_done(input int budget);
        int cyc;
        cyc = 0;
        while (!gen_done && cyc < budget) begin
            tick(1);
            cyc++;
        end
        vectors++;
        if (!gen_done) begin
            miscompares++;
            $display("FAIL gen_done_wait: got no pulse within %0d cycles expected pulse", budget);
        end
    endtask

    task automatic finish_checks(input int exp_cnt, input logic exp_to, input logic [255:0] b);
        check("move_count", move_count, (exp_cnt > 255) ? 255 : exp_cnt);
        check("timeout", timeout, exp_to);
        check("col_state", col_state, b);
        check("moves_left", exp_moves.size(), 0);
        check("reads_left", exp_pops.size(), 0);
        tick(1);
        check("gen_done_width", gen_done, 0);
        check("busy_after", busy, 0);
        check("count_hold", move_count, (exp_cnt > 255) ? 255 : exp_cnt);
    endtask

    // Column FIFO model: non-showahead, q valid the cycle after the read enable.
    initial begin
        logic [7:0] rd;
        int         c;
        int         idx;
        col_empty = 8'hFF;
        col_data  = '0;
        forever begin
            @(negedge clk);
            rd = col_rden;
            @(posedge clk);
            #1;
            if (rd != 8'd0) begin
                check("rden_onehot", $onehot(rd), 1);
                c = 0;
                for (int i = 7; i >= 0; i--) if (rd[i]) c = i;
                if (exp_pops.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL read_order: got read of col %0d expected no read", c);
                end else begin
                    check("read_order", c, exp_pops.pop_front());
                end
                idx = -1;
                for (int i = store.size() - 1; i >= 0; i--) if (store[i].col == c) idx = i;
                if (idx >= 0) begin
                    col_data[160*c +: 160] = store[idx].w;
                    store.delete(idx);
                end
            end
            for (int k = 0; k < 8; k++) begin
                col_empty[k] = 1'b1;
                for (int i = 0; i < store.size(); i++) if (store[i].col == k) col_empty[k] = 1'b0;
            end
        end
    end

    // Consumer ready pattern.
    initial begin
        move_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       move_ready = 1'b1;
                1:       move_ready = ~move_ready;
                default: move_ready = 1'b0;
            endcase
        end
    end

    // Output stream checker: handshakes against the expected queue, hold while stalled.
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (move_valid) valid_cycles++;
            if (prev_hold) begin
                check("hold_valid", move_valid, 1);
                check("hold_data", move_out, prev_data);
            end
            if (move_valid && move_ready) begin
                hs_count++;
                if (exp_moves.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL move: got %0h expected no move", move_out);
                end else begin
                    check("move", move_out, exp_moves.pop_front());
                end
            end
            prev_hold = move_valid && !move_ready;
            prev_data = move_out;
        end
    end

    initial begin
        logic [159:0] w;
        int           n;
        int           g;
        int           hs0;
        int           v0;
        logic [255:0] b;

        reset = 1'b1;
        start = 1'b0;
        board_state = '0;
        col_done = 8'h00;
        tick(2);
        check("rst_col_state", col_state, 0);
        check("rst_col_reset", col_reset, 1);
        check("rst_rden", col_rden, 0);
        check("rst_valid", move_valid, 0);
        check("rst_move_out", move_out, 0);
        check("rst_busy", busy, 0);
        check("rst_count", move_count, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;
        tick(1);
        check("idle_col_reset", col_reset, 0);

        // 1: column 2, slots 0 and 3 valid, col_done rises 3 cycles after RST
        clear_model();
        w = mk_word(8'h09, 18'h10000);
        w[0 +: 19]  = 19'h00A1B;
        w[60 +: 19] = 19'h01234;
        add_word(2, w);
        build_expected();
        check("model_m0", exp_moves[0], 19'h00A1B);
        check("model_m1", exp_moves[1], 19'h01234);
        check("model_n", exp_moves.size(), 2);
        ready_mode = 0;
        col_done = 8'h00;
        hs0 = hs_count;
        b = {8{32'hA5C3_1E0F}};
        pulse_start(b);
        check("busy_start", busy, 1);
        count_rst(n);
        check("rst_cycles", n, 2);
        tick(2);
        col_done = 8'hFF;
        wait_done(200);
        check("t1_handshakes", hs_count - hs0, 2);
        finish_checks(2, 1'b0, b);

        // 2: column 0, all eight slots valid, ready toggling
        clear_model();
        add_word(0, mk_word(8'hFF, 18'h02000));
        build_expected();
        ready_mode = 1;
        hs0 = hs_count;
        b = {64{4'h3}};
        pulse_start(b);
        wait_done(300);
        check("t2_handshakes", hs_count - hs0, 8);
        finish_checks(8, 1'b0, b);

        // 3: columns 7 and 1 with two words each
        clear_model();
        add_word(7, mk_word(8'h81, 18'h07000));
        add_word(7, mk_word(8'h3C, 18'h07100));
        add_word(1, mk_word(8'h05, 18'h01000));
        add_word(1, mk_word(8'hF0, 18'h01100));
        build_expected();
        check("model_pop0", exp_pops[0], 1);
        check("model_pop1", exp_pops[1], 1);
        check("model_pop2", exp_pops[2], 7);
        check("model_pop3", exp_pops[3], 7);
        ready_mode = 0;
        n = exp_moves.size();
        b = {32{8'h5A}};
        pulse_start(b);
        wait_done(300);
        finish_checks(n, 1'b0, b);

        // 4: col_done stuck at 7F, watchdog expires after 1023 GEN cycles
        clear_model();
        add_word(3, mk_word(8'h49, 18'h03000));
        build_expected();
        col_done = 8'h7F;
        b = {16{16'hBEEF}};
        pulse_start(b);
        count_rst(n);
        check("t4_rst_cycles", n, 2);
        g = 0;
        while (!timeout && g < 1200) begin
            tick(1);
            g++;
        end
        check("gen_cycles", g, 1023);
        wait_done(200);
        finish_checks(3, 1'b1, b);

        // 4b: col_done arrives in the watchdog's last cycle, timeout stays 0
        clear_model();
        add_word(5, mk_word(8'h02, 18'h05000));
        build_expected();
        col_done = 8'h7F;
        b = {16{16'h1234}};
        pulse_start(b);
        count_rst(n);
        tick(1022);
        col_done = 8'hFF;
        wait_done(200);
        finish_checks(1, 1'b0, b);

        // 5: all-invalid word then a one-move word
        clear_model();
        add_word(4, mk_word(8'h00, 18'h04000));
        add_word(5, mk_word(8'h40, 18'h05500));
        build_expected();
        v0 = valid_cycles;
        b = {32{8'hC3}};
        pulse_start(b);
        wait_done(200);
        check("t5_valid_cycles", valid_cycles - v0, 1);
        finish_checks(1, 1'b0, b);

        // 6: saturation at 255 with 256 valid moves
        clear_model();
        for (int i = 0; i < 32; i++) add_word(6, mk_word(8'hFF, 18'(i * 512)));
        build_expected();
        check("model_sat_n", exp_moves.size(), 256);
        b = {8{32'h0F0F_0F0F}};
        pulse_start(b);
        wait_done(1000);
        check("sat_count", move_count, 255);
        finish_checks(256, 1'b0, b);

        // 7: start while busy is ignored, reset mid-SER returns everything to reset values
        clear_model();
        add_word(0, mk_word(8'hFF, 18'h0A000));
        build_expected();
        ready_mode = 2;
        b = {8{32'h1111_2222}};
        pulse_start(b);
        n = 0;
        while (!move_valid && n < 50) begin
            tick(1);
            n++;
        end
        check("t7_in_ser", move_valid, 1);
        pulse_start({8{32'h9999_7777}});
        check("t7_busy", busy, 1);
        check("t7_col_state", col_state, b);
        check("t7_move_out", move_out, exp_moves[0]);
        check("t7_count", move_count, 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        clear_model();
        check("mid_col_state", col_state, 0);
        check("mid_col_reset", col_reset, 1);
        check("mid_rden", col_rden, 0);
        check("mid_valid", move_valid, 0);
        check("mid_move_out", move_out, 0);
        check("mid_busy", busy, 0);
        check("mid_gen_done", gen_done, 0);
        check("mid_count", move_count, 0);
        check("mid_timeout", timeout, 0);
        reset = 1'b0;
        tick(1);
        check("post_col_reset", col_reset, 0);
        tick(5);
        check("post_busy", busy, 0);
        check("post_valid", move_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
